// File: rtl/cnt_timer_pkg.sv
// cnt_timer_pkg: shared state encoding and default widths for the counter timer.
package cnt_timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int CNT_WIDTH   = 8;
    localparam int CNT_PRESC_W = 4;
endpackage

// File: rtl/cnt_timer_ctrl_prescaler.sv
// cnt_prescaler: count-enable generator, one enable every presc_i+1 cycles while not cleared.
module cnt_prescaler
    import cnt_timer_pkg::*;
#(
    parameter int PRESC_W = CNT_PRESC_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               en_o
);
    logic [PRESC_W-1:0] pcnt;
    assign en_o = pcnt == presc_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pcnt <= '0;
        else if (clr_i) pcnt <= '0;
        else pcnt <= en_o ? '0 : pcnt + 1'b1;
    end
endmodule

// File: rtl/cnt_timer_ctrl.sv
// cnt_timer_ctrl: command-driven one-shot/periodic timer sequencer over the free-running counter.
// Optional prescaled count enable with CNT_PRESCALER_EN.
module cnt_timer_ctrl
    import cnt_timer_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH,
    parameter int PRESC_W = CNT_PRESC_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [WIDTH-1:0]   cmd_period_i,
    input  logic               cmd_oneshot_i,
`ifdef CNT_PRESCALER_EN
    input  logic [PRESC_W-1:0] cmd_presc_i,
`endif
    input  logic               stop_i,
    output logic [WIDTH-1:0]   cnt_o,
    output logic               busy_o,
    output logic               tick_o,
    output logic               done_o
);
    state_e state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    logic oneshot_q, oneshot_d, en, at_tc;

`ifdef CNT_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) presc_q <= '0;
        else if (state_q == IDLE && cmd_valid_i) presc_q <= cmd_presc_i;
    end
    // held clear outside RUN so it always starts from zero on RUN entry
    cnt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q != RUN || stop_i),
        .presc_i(presc_q),
        .en_o   (en)
    );
`else
    logic [PRESC_W-1:0] unused_presc;
    assign unused_presc = '0;
    assign en = 1'b1;
`endif

    assign at_tc       = cnt_q == period_q;
    assign cnt_o       = cnt_q;
    assign cmd_ready_o = state_q == IDLE;
    assign busy_o      = state_q == RUN;
    assign done_o      = state_q == DONE;
    assign tick_o      = busy_o && at_tc && en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                period_d  = cmd_period_i;
                oneshot_d = cmd_oneshot_i;
                state_d   = cmd_period_i == '0 ? DONE : RUN;
            end
            RUN: begin
                // stop outranks the terminal-count transition
                if (stop_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (en) begin
                    state_d = at_tc && oneshot_q ? DONE : RUN;
                    cnt_d   = !at_tc ? cnt_q + 1'b1 : oneshot_q ? cnt_q : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
        end
    end
endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// tb_cnt_timer_ctrl: directed and random checks of cnt_timer_ctrl against an expected-trace model.
module tb_cnt_timer_ctrl;
    localparam int W = 8;
    logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_oneshot = 0, stop = 0;
    logic [W-1:0] cmd_period = '0, cnt;
    logic ready, busy, tick, done;
`ifdef CNT_PRESCALER_EN
    logic [3:0] cmd_presc = '0;
`endif
    int total = 0, bad = 0, ticks = 0;

    typedef struct packed {logic [W-1:0] cnt; logic busy, tick, done, ready;} obs_t;
    typedef struct packed {obs_t o; logic stop;} ent_t;
    ent_t q[$];

    cnt_timer_ctrl #(.WIDTH(W), .PRESC_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (ready),
        .cmd_period_i (cmd_period),
        .cmd_oneshot_i(cmd_oneshot),
`ifdef CNT_PRESCALER_EN
        .cmd_presc_i  (cmd_presc),
`endif
        .stop_i       (stop),
        .cnt_o        (cnt),
        .busy_o       (busy),
        .tick_o       (tick),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        return {cnt, busy, tick, done, ready};
    endfunction

    function automatic ent_t mk(input int c, input bit b, input bit t, input bit d, input bit r, input bit s);
        return {W'(c), b, t, d, r, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input obs_t o, input obs_t e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got cnt=%0d busy=%b tick=%b done=%b ready=%b, want cnt=%0d busy=%b tick=%b done=%b ready=%b",
                   tag, o.cnt, o.busy, o.tick, o.done, o.ready, e.cnt, e.busy, e.tick, e.done, e.ready);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0d, want %0d", tag, o, e);
        end
    endtask

    // Expected per-cycle trace for one accepted command: count i runs at cnt (i/d) mod (p+1),
    // a tick when the count sits at p on an enable cycle, stop at cycle n_stop (-1 = never).
    task automatic build(input int p, input bit os, input int d, input int n_stop);
        int c;
        bit t, s;
        if (p == 0) q.push_back(mk(0, 0, 0, 1, 0, 1'($urandom % 2)));
        else for (int i = 0; i < 5000; i++) begin
            c = (i / d) % (p + 1);
            t = c == p && i % d == d - 1;
            s = i == n_stop;
            q.push_back(mk(c, 1, t, 0, 0, s));
            if (s) break;
            if (os && t) begin
                q.push_back(mk(p, 0, 0, 1, 0, 1'($urandom % 2)));
                break;
            end
        end
        q.push_back(mk(0, 0, 0, 0, 1, 1'($urandom % 2)));
    endtask

    task automatic drain(input string tag, input bit jitter);
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            stop = e.stop;
            if (tick) ticks++;
            chk(tag, cur(), e.o);
            if (q.size() > 0) begin
                if (jitter) cmd_period = W'($urandom_range(1, 255));
                step();
            end
        end
        stop = 0;
    endtask

    task automatic issue(input int p, input bit os);
        cmd_valid = 1;
        cmd_period = W'(p);
        cmd_oneshot = os;
        step();
        cmd_valid = 0;
    endtask

    initial begin
        int p, n;
        bit os;
        step();
        step();
        chk("reset_hold", cur(), mk(0, 0, 0, 0, 1, 0).o);
        rst_n = 1;
        step();
        chk("reset_release", cur(), mk(0, 0, 0, 0, 1, 0).o);

        issue(5, 1); build(5, 1, 1, -1); ticks = 0; drain("oneshot5", 0);
        chk_int("oneshot5_ticks", ticks, 1);

        issue(3, 0); build(3, 0, 1, 20); ticks = 0; drain("periodic3", 0);
        chk_int("periodic3_ticks", ticks, 5);

        issue(0, 1); build(0, 1, 1, -1); ticks = 0; drain("zero_oneshot", 0);
        issue(0, 0); build(0, 0, 1, -1); drain("zero_periodic", 0);
        chk_int("zero_ticks", ticks, 0);

        issue(255, 1); build(255, 1, 1, -1); ticks = 0; drain("max_period", 0);
        chk_int("max_ticks", ticks, 1);

        issue(4, 1); build(4, 1, 1, 4); drain("stop_at_tc", 0);

        stop = 1;
        step();
        chk("stop_idle", cur(), mk(0, 0, 0, 0, 1, 0).o);
        issue(2, 1); stop = 0; build(2, 1, 1, -1); drain("cmd_and_stop", 0);

        cmd_valid = 1; cmd_period = 3; cmd_oneshot = 1;
        step();
        build(3, 1, 1, -1); drain("backpressure", 1);
        cmd_period = 6; cmd_oneshot = 1;
        step();
        cmd_valid = 0;
        build(6, 1, 1, -1); drain("bp_next", 0);

`ifdef CNT_PRESCALER_EN
        cmd_presc = 2;
        issue(2, 0); build(2, 0, 3, 27); ticks = 0; drain("presc", 0);
        chk_int("presc_ticks", ticks, 3);
        cmd_presc = 0;
`endif

        for (int k = 0; k < 10; k++) begin
            p = $urandom_range(0, 12);
            os = 1'($urandom % 2);
            n = os ? ($urandom % 3 == 0 ? int'($urandom_range(0, p)) : -1) : int'($urandom_range(0, 30));
            issue(p, os);
            build(p, os, 1, n);
            drain("random", 0);
        end

        issue(50, 0);
        step(); step(); step();
        #2 rst_n = 0;
        #1 chk("async_reset", cur(), mk(0, 0, 0, 0, 1, 0).o);
        step();
        rst_n = 1;
        step();
        chk("after_reset", cur(), mk(0, 0, 0, 0, 1, 0).o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cnt_timer_ctrl.md
Name: cnt_timer_ctrl

Overview:
Sequencer for the board's free-running counter datapath. It turns the counter into a programmable timer. A requester issues a command (period, one-shot/periodic) over a valid/ready handshake. The block runs the count, flags each terminal count, and returns to idle on completion or abort. It sits between the fabric-side control logic and the counter/LED output in top-level designs.

Parameters:
- WIDTH, 8: counter and period width in bits.
- PRESC_W, 4: prescaler divide-field width. Used only with CNT_PRESCALER_EN.

Ports:
- clk_i, input, 1: sole clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- cmd_valid_i, input, 1: command request.
- cmd_ready_o, output, 1: block can accept a command. High only in IDLE.
- cmd_period_i, input, WIDTH: terminal count value, sampled on handshake.
- cmd_oneshot_i, input, 1: 1 = stop after first terminal count; 0 = periodic. Sampled on handshake.
- cmd_presc_i, input, PRESC_W: count-enable divide minus 1. Present only with CNT_PRESCALER_EN.
- stop_i, input, 1: abort the running timer.
- cnt_o, output, WIDTH: current count.
- busy_o, output, 1: high in RUN.
- tick_o, output, 1: high for each cycle in which cnt_o == period while in RUN.
- done_o, output, 1: one-cycle pulse on one-shot completion.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: state=IDLE, cnt_o=0, busy_o=0, tick_o=0, done_o=0, cmd_ready_o=1. Latched period, mode and prescale are cleared to 0.
- Reset asserted mid-run: everything returns to the reset values immediately, asynchronously. Nothing pending survives.
- States: IDLE, RUN, DONE. State, counter and latches are registered. All outputs decode from registers only.
- IDLE:
  - cmd_ready_o=1, cnt_o=0.
  - On cmd_valid_i & cmd_ready_o at clock edge N: latch period and mode.
  - If period != 0: go to RUN at edge N. cnt_o=0 in cycle N+1.
  - If period == 0: go to DONE directly. done_o pulses in cycle N+1 (both modes). tick_o is not asserted.
- RUN:
  - busy_o=1, cmd_ready_o=0. Commands are ignored; cmd_valid_i may stay high.
  - On each count enable (every cycle without the optional feature):
    - cnt_o < period: cnt_o increments by 1.
    - cnt_o == period, periodic: cnt_o wraps to 0.
    - cnt_o == period, one-shot: go to DONE.
  - tick_o = (state==RUN) & (cnt_o==period). With enable every cycle, periodic ticks recur every period+1 cycles.
  - No modular wrap beyond period: arithmetic is WIDTH-bit unsigned, and period=2^WIDTH-1 is legal.
- DONE:
  - Lasts exactly one cycle, with done_o=1, busy_o=0, cmd_ready_o=0 and cnt_o holding the final value.
  - Then goes to IDLE with cnt_o cleared.
- stop_i:
  - Sampled high in RUN: next state is IDLE and cnt_o clears. No done_o, and no further tick.
  - stop_i in the same cycle as terminal count: stop wins. tick_o is still visible that cycle because it is combinational on current state, but DONE/wrap is suppressed.
  - stop_i in IDLE or DONE: ignored.
- Simultaneous command and stop in IDLE: command accepted, stop ignored.

Optional Feature:
- Macro CNT_PRESCALER_EN.
- Defined:
  - cmd_presc_i exists and is latched on handshake.
  - A PRESC_W-bit prescaler counts 0..presc and generates a count enable once every presc+1 cycles. The first enable occurs presc+1 cycles after RUN entry.
  - The prescaler clears on RUN entry, on stop_i and on reset.
  - tick_o is qualified by the enable, so it is a single-cycle pulse.
- Undefined: the port is absent and the count enable is tied to 1.

Decomposition:
- Package cnt_timer_pkg: state_e enum (IDLE, RUN, DONE) and default-width constants.
- Natural sub-module: cnt_prescaler (enable generator), instantiated only under CNT_PRESCALER_EN.

Test Plan:
1. Reset and idle: hold rst_ni=0 for 2 cycles, then release. Required: cnt_o=0, cmd_ready_o=1, busy_o=0. Assert rst_ni=0 mid-RUN; cnt_o=0 immediately, without waiting for a clock edge.
2. One-shot, period=5:
   - cnt_o steps 0,1,2,3,4,5.
   - tick_o high for 1 cycle at cnt_o=5.
   - done_o pulses in the next cycle, then cmd_ready_o=1 and cnt_o=0.
   - Total: 8 cycles from handshake to ready.
3. Periodic, period=3, run for 20 cycles: tick_o asserted every 4th cycle (5 ticks); done_o never asserted. Then stop_i=1 for 1 cycle: next cycle IDLE, cnt_o=0, no done_o.
4. Boundaries:
   - period=0: done_o in the cycle after the handshake, no tick.
   - period=255 (WIDTH=8), one-shot: done after 256 counts with no overflow.
   - stop_i coincident with cnt_o==period: IDLE next cycle, no done_o.
5. Back-pressure: hold cmd_valid_i=1 with changing period during RUN. Only the first command is accepted; the next is accepted in the first IDLE cycle after DONE.
6. With CNT_PRESCALER_EN, presc=2, period=2, periodic:
   - cnt_o advances every 3 cycles.
   - tick_o is a 1-cycle pulse every 9 cycles.
